data_store_buffer: RTL and testbench



---
 rtl/data_store_buffer.sv | 90 +++++++++
 tb/tb_data_store_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-store FIFO draining to data memory, with loads serialised behind queued stores
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] q_addr [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [3:0]  q_mask [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic op_read, full, push, pop, mem_idle, issue_wr, issue_rd, busy_exit;
  assign full = count == (AW+1)'(DEPTH);
  assign push = memwrite & ~full;
  assign mem_idle = ~mem_clk_stall;
  assign issue_wr = state == IDLE & mem_idle & count != '0;
  assign issue_rd = state == IDLE & mem_idle & count == '0 & memread & ~memwrite;
  assign busy_exit = state == BUSY & mem_idle;
  assign pop = busy_exit & ~op_read;
  assign clk_stall = reset_n & ((memwrite & full) | (memread & ~memwrite & state != DONE));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = issue_wr | issue_rd ? REQ : IDLE;
      REQ: state_nx = BUSY;
      BUSY: state_nx = mem_idle ? (op_read ? DONE : IDLE) : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr] <= addr;
      q_data[wr_ptr] <= write_data;
      q_mask[wr_ptr] <= sign_mask;
    end
  always_ff @(posedge clk)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (!reset_n) begin
      mem_addr <= '0;
      mem_write_data <= '0;
      mem_sign_mask <= '0;
      mem_memwrite <= 1'b0;
      mem_memread <= 1'b0;
      read_data <= '0;
      op_read <= 1'b0;
    end else begin
      mem_memwrite <= issue_wr;
      mem_memread <= issue_rd;
      if (issue_wr) begin
        mem_addr <= q_addr[rd_ptr];
        mem_write_data <= q_data[rd_ptr];
        mem_sign_mask <= q_mask[rd_ptr];
        op_read <= 1'b0;
      end else if (issue_rd) begin
        mem_addr <= addr;
        mem_sign_mask <= sign_mask;
        op_read <= 1'b1;
      end
      if (busy_exit & op_read) read_data <= mem_read_data;
    end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: scoreboard bench for the posted-store buffer against a fixed-latency memory model
module tb_data_store_buffer;
  logic clk = 0, reset_n = 0, memwrite = 0, memread = 0;
  logic [31:0] addr = 0, write_data = 0;
  logic [3:0] sign_mask = 0;
  logic [31:0] read_data, mem_addr, mem_write_data, mem_read_data;
  logic [3:0] mem_sign_mask;
  logic clk_stall, mem_memwrite, mem_memread, mem_clk_stall;
  int pass_cnt = 0, total_cnt = 0, busy = 0, cyc = 0, last_wr = -1000, st;
  logic prev_pulse = 0, prev_stall = 0;
  logic [67:0] wq[$];
  logic [35:0] raq[$];
  logic [31:0] rq[$];
  logic [67:0] we;
  logic [35:0] re;
  logic [31:0] rd;
  logic [31:0] mem [256];
  always #5 clk = ~clk;
  data_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .clk_stall(clk_stall), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );
  assign mem_clk_stall = busy != 0;
  always @(posedge clk) begin
    if (!reset_n) mem[4] <= 32'hCAFEF00D;
    if (mem_memwrite) mem[mem_addr[7:0]] <= mem_write_data;
    if (mem_memread) mem_read_data <= mem[mem_addr[7:0]];
    busy <= (mem_memwrite | mem_memread) ? 2 : (busy > 0 ? busy - 1 : 0);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (reset_n && (mem_memwrite || mem_memread)) begin
      check("pulse_exclusive", {31'b0, mem_memwrite & mem_memread}, 0);
      check("pulse_gap", {31'b0, prev_pulse}, 0);
      check("issue_when_mem_idle", {31'b0, prev_stall}, 0);
    end
    if (reset_n && mem_memwrite) begin
      if (wq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %h expected no write", mem_addr);
      end else begin
        we = wq.pop_front();
        check("wr_addr", mem_addr, we[67:36]);
        check("wr_data", mem_write_data, we[35:4]);
        check("wr_mask", {28'b0, mem_sign_mask}, {28'b0, we[3:0]});
      end
      last_wr = cyc;
    end
    if (reset_n && mem_memread) begin
      if (raq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
      end else begin
        re = raq.pop_front();
        check("rd_addr", mem_addr, re[35:4]);
        check("rd_mask", {28'b0, mem_sign_mask}, {28'b0, re[3:0]});
      end
      check("rd_after_store_done", {31'b0, cyc - last_wr >= 5}, 1);
    end
    if (reset_n && memread && !memwrite && !clk_stall) begin
      if (rq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_release: got %h expected no load", read_data);
      end else begin
        rd = rq.pop_front();
        check("read_data", read_data, rd);
      end
    end
    prev_pulse = mem_memwrite | mem_memread;
    prev_stall = mem_clk_stall;
    cyc++;
  end
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output int stalls);
    logic s;
    addr = a;
    write_data = d;
    sign_mask = m;
    memwrite = 1;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      s = clk_stall;
      @(posedge clk);
      if (!s) begin
        wq.push_back({a, d, m});
        break;
      end
      stalls++;
      if (stalls > 50) begin
        total_cnt++;
        $display("FAIL store_timeout: got %0d stall cycles expected acceptance", stalls);
        break;
      end
    end
    #1 memwrite = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp, output int stalls);
    addr = a;
    sign_mask = m;
    memwrite = 0;
    memread = 1;
    raq.push_back({a, m});
    rq.push_back(exp);
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!clk_stall) break;
      stalls++;
      if (stalls > 100) begin
        total_cnt++;
        $display("FAIL load_timeout: got %0d stall cycles expected release", stalls);
        break;
      end
    end
    @(posedge clk);
    #1 memread = 0;
  endtask
  task automatic drain_wait();
    for (int n = 0; n < 500 && wq.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    if (wq.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", wq.size());
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    memread = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_clk_stall", {31'b0, clk_stall}, 0);
    check("rst_read_data", read_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_mem_mask", {28'b0, mem_sign_mask}, 0);
    check("rst_pulses", {30'b0, mem_memwrite, mem_memread}, 0);
    check("rst_count", {29'b0, dut.count}, 0);
    @(posedge clk);
    #1 memread = 0;
    reset_n = 1;
    load(32'h1004, 4'b0010, 32'hCAFEF00D, st);
    check("load_latency_stalls", st, 5);
    store(32'h1000, 32'hDEADBEEF, 4'b0100, st);
    check("single_store_stalls", st, 0);
    drain_wait();
    load(32'h1000, 4'b0100, 32'hDEADBEEF, st);
    for (int i = 0; i < 5; i++) begin
      store(32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'b0010, st);
      check(i == 4 ? "fifth_store_stalls" : "fill_store_stalls", st, i == 4 ? 2 : 0);
    end
    drain_wait();
    store(32'h1001, 32'h00000012, 4'b0001, st);
    load(32'h1001, 4'b0101, 32'h00000012, st);
    check("load_behind_store_stalls", st, 10);
    drain_wait();
    for (int i = 0; i < 3; i++) store(32'h1100 + 32'(4 * i), 32'hC0000000 + 32'(i), 4'b1000, st);
    reset_n = 0;
    memread = 1;
    @(negedge clk);
    check("stall_forced_low_in_reset", {31'b0, clk_stall}, 0);
    @(posedge clk);
    #1 reset_n = 1;
    memread = 0;
    wq.delete();
    @(negedge clk);
    check("mid_rst_read_data", read_data, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_write_data, 0);
    check("mid_rst_pulses", {30'b0, mem_memwrite, mem_memread}, 0);
    check("mid_rst_count", {29'b0, dut.count}, 0);
    @(posedge clk);
    #1;
    store(32'h2000, 32'h11223344, 4'b1111, st);
    load(32'h2000, 4'b1111, 32'h11223344, st);
    drain_wait();
    store(32'h1200, 32'h0000AAAA, 4'b0011, st);
    store(32'h1204, 32'h0000BBBB, 4'b0011, st);
    repeat (3) @(posedge clk);
    #1;
    store(32'h1208, 32'h0000CCCC, 4'b0011, st);
    check("pushpop_stalls", st, 0);
    @(negedge clk);
    check("pushpop_count", {29'b0, dut.count}, 2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) store(32'h3000 + 32'(4 * i), 32'hB0000000 + 32'(i * 17), 4'(i), st);
    drain_wait();
    load(32'h301C, 4'b0111, 32'hB0000077, st);
    drain_wait();
    check("write_queue_empty", wq.size(), 0);
    check("read_queue_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
